// File: rtl/tdm_pkg.sv
// Shared TDM definitions: channel tag type, tag record and slot wrap helper.
// Used by the scheduler, and by the serializer/deserializer and FIR that
// share the same channel numbering.
package tdm_pkg;

    // System-wide channel count; the tag width follows from it. Every block
    // sharing these tags must be built for a channel count with this width.
    localparam int TDM_MAX_CHANNELS = 4;
    localparam int TDM_CH_W         = $clog2(TDM_MAX_CHANNELS);

    typedef logic [TDM_CH_W-1:0] tdm_ch_t;

    typedef struct packed {
        logic    v;
        tdm_ch_t ch;
    } tdm_tag_t;

    // Round-robin successor: wraps after the last channel, never past it.
    function automatic tdm_ch_t next_slot(input tdm_ch_t s, input tdm_ch_t last);
        return (s == last) ? '0 : s + tdm_ch_t'(1);
    endfunction

endpackage

// File: rtl/tdm_fir_scheduler_tag_delay.sv
// Fixed-depth shift register for per-sample side information. It runs every
// cycle so that anything already in flight always reaches the far end.
module tdm_tag_delay #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  T     tag,
    output T     delayed
);

    T stage [DEPTH];

    // Shift one stage per clock; reset empties the whole line.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/tdm_fir_scheduler.sv
// Round-robin TDM front/back end for one shared, pipelined FIR. Each channel
// owns a one-sample hold register; the slot owner's sample is issued with its
// channel tag, the tag rides a delay line matched to the FIR, and the returning
// result is steered back to the originating channel.
module tdm_fir_scheduler
    import tdm_pkg::*;
#(
    parameter int  NUM_CHANNELS = 4,
    parameter int  DATA_WIDTH   = 16,
    parameter int  FIR_LATENCY  = 8,
    localparam int CH_W         = $clog2(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [NUM_CHANNELS-1:0]            in_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CHANNELS-1:0]            in_ready,
    output logic                               fir_in_valid,
    output logic [DATA_WIDTH-1:0]              fir_in_data,
    output logic [CH_W-1:0]                    fir_in_ch,
    input  logic                               fir_out_valid,
    input  logic [DATA_WIDTH-1:0]              fir_out_data,
    output logic [NUM_CHANNELS-1:0]            out_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]                    slot,
    output logic                               sync_err
);

    localparam tdm_ch_t LAST_CH = tdm_ch_t'(NUM_CHANNELS - 1);

    logic [CH_W-1:0]       slot_q;
    logic [DATA_WIDTH-1:0] in_word [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] hold    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] hold_v;
    logic [DATA_WIDTH-1:0] result  [NUM_CHANNELS];
    logic                  issue;
    tdm_tag_t              tag_in;
    tdm_tag_t              tag_out;
    logic [CH_W-1:0]       tag_ch;

    // Flat views of the packed per-channel buses.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lanes
        assign in_word[c]                            = in_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = result[c];
    end

    assign slot   = slot_q;
    assign issue  = enable & hold_v[slot_q];
    assign tag_in = '{v: fir_in_valid, ch: tdm_ch_t'(fir_in_ch)};
    assign tag_ch = CH_W'(tag_out.ch);

    // Slot counter: advances only while enabled, wrapping after the last channel.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every block sees pre-edge values.
        if (reset) begin
            slot_q <= '0;
        end else if (enable) begin
            slot_q <= CH_W'(next_slot(tdm_ch_t'(slot_q), LAST_CH));
        end
    end

    // A full hold register still accepts when it is being issued this cycle.
    always_comb begin
        // NOTE: default first so no path through the block leaves a bit unassigned (no latch).
        in_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            in_ready[c] = ~hold_v[c] | (enable & (slot_q == CH_W'(c)));
        end
    end

    // Hold registers and the issue register; capture wins over the issue clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the small hold array is reset too, so no sample data survives reset.
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                hold[c] <= '0;
            end
            hold_v       <= '0;
            fir_in_valid <= 1'b0;
            fir_in_data  <= '0;
            fir_in_ch    <= '0;
        end else begin
            fir_in_valid <= issue;
            if (issue) begin
                fir_in_data <= hold[slot_q];
                fir_in_ch   <= slot_q;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (in_valid[c] & in_ready[c]) begin
                    hold[c]   <= in_word[c];
                    hold_v[c] <= 1'b1;
                end else if (issue && (slot_q == CH_W'(c))) begin
                    hold_v[c] <= 1'b0;
                end
            end
        end
    end

    // Channel tags follow the samples through a line as deep as the FIR.
    tdm_tag_delay #(
        .DEPTH (FIR_LATENCY),
        .T     (tdm_tag_t)
    ) u_tag_line (
        .clk     (clk),
        .reset   (reset),
        .tag     (tag_in),
        .delayed (tag_out)
    );

    // Egress: steer each tagged result home; flag strobe/tag disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                result[c] <= '0;
            end
            out_valid <= '0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= '0;
            if (tag_out.v) begin
                result[tag_ch]    <= fir_out_data;
                out_valid[tag_ch] <= 1'b1;
            end
            if (fir_out_valid != tag_out.v) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdm_fir_scheduler.sv
// Bench for tdm_fir_scheduler: a 4-channel and a 3-channel instance, each fed
// by a behavioural FIR (delay of FIR_LATENCY, result = sample + 1). Expected
// traffic comes from per-channel sample queues and a timestamped result board.
module tb_tdm_fir_scheduler;

    localparam int L  = 8;
    localparam int DW = 16;
    localparam int M_HOLD = 0;
    localparam int M_SEQ  = 1;
    localparam int M_RAND = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    logic clk;
    logic reset;

    logic          enable;
    logic [3:0]    in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]    in_ready;
    logic          fir_in_valid;
    logic [DW-1:0] fir_in_data;
    logic [1:0]    fir_in_ch;
    logic          fir_out_valid;
    logic [DW-1:0] fir_out_data;
    logic [3:0]    out_valid;
    logic [4*DW-1:0] out_data;
    logic [1:0]    slot;
    logic          sync_err;

    logic          enable3;
    logic [2:0]    in_valid3;
    logic [3*DW-1:0] in_data3;
    logic [2:0]    in_ready3;
    logic          fir_in_valid3;
    logic [DW-1:0] fir_in_data3;
    logic [1:0]    fir_in_ch3;
    logic          fir_out_valid3;
    logic [DW-1:0] fir_out_data3;
    logic [2:0]    out_valid3;
    logic [3*DW-1:0] out_data3;
    logic [1:0]    slot3;
    logic          sync_err3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_iss = 0;
    int n_iss3 = 0;

    logic [DW-1:0] iss_q [4][$];
    exp_t          out_q [4][$];
    logic [DW-1:0] q3 [$];
    exp_t          o3 [$];
    int            slot_m;
    int            slot3_m;
    bit            err_m;
    bit            force_fov;
    bit            pv  [L+1];
    bit [DW-1:0]   pd  [L+1];
    bit            pv3 [L+1];
    bit [DW-1:0]   pd3 [L+1];
    int            mode;
    int            k [4];
    int            k3;

    tdm_fir_scheduler #(.NUM_CHANNELS(4), .DATA_WIDTH(DW), .FIR_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fir_in_valid(fir_in_valid), .fir_in_data(fir_in_data), .fir_in_ch(fir_in_ch),
        .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
        .out_valid(out_valid), .out_data(out_data), .slot(slot), .sync_err(sync_err)
    );

    tdm_fir_scheduler #(.NUM_CHANNELS(3), .DATA_WIDTH(DW), .FIR_LATENCY(L)) dut3 (
        .clk(clk), .reset(reset), .enable(enable3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .fir_in_valid(fir_in_valid3), .fir_in_data(fir_in_data3), .fir_in_ch(fir_in_ch3),
        .fir_out_valid(fir_out_valid3), .fir_out_data(fir_out_data3),
        .out_valid(out_valid3), .out_data(out_data3), .slot(slot3), .sync_err(sync_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pending();
        int n = q3.size() + o3.size();
        for (int c = 0; c < 4; c++) n += iss_q[c].size() + out_q[c].size();
        return n;
    endfunction

    // One clock: sample handshakes before the edge, score outputs after it,
    // advance the FIR models and regenerate stimulus.
    task automatic step();
        logic [3:0]    acc;
        logic [2:0]    acc3;
        logic          rst_s, en_s, en3_s, mism, exp_iss, exp_pulse;
        logic [DW-1:0] d;
        exp_t          e;
        @(negedge clk);
        rst_s = reset;
        en_s  = enable;
        en3_s = enable3;
        mism  = (fir_out_valid != pv[L]);
        if (!rst_s) begin
            for (int c = 0; c < 4; c++)
                check("in_ready", in_ready[c], (iss_q[c].size() == 0) || (en_s && slot_m == c));
            check("in_ready3_ch2", in_ready3[2], (q3.size() == 0) || (en3_s && slot3_m == 2));
        end
        acc  = rst_s ? 4'b0 : (in_valid & in_ready);
        acc3 = rst_s ? 3'b0 : (in_valid3 & in_ready3);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            for (int c = 0; c < 4; c++) begin
                iss_q[c].delete();
                out_q[c].delete();
            end
            q3.delete();
            o3.delete();
            slot_m  = 0;
            slot3_m = 0;
            err_m   = 1'b0;
            for (int i = 0; i <= L; i++) begin
                pv[i]  = 1'b0;
                pv3[i] = 1'b0;
            end
        end else begin
            exp_iss = en_s && (iss_q[slot_m].size() != 0);
            check("fir_in_valid", fir_in_valid, exp_iss);
            if (exp_iss) begin
                d = iss_q[slot_m].pop_front();
                check("fir_in_ch", fir_in_ch, slot_m);
                check("fir_in_data", fir_in_data, d);
                e.d   = d + 1'b1;
                e.due = cyc + L + 1;
                out_q[slot_m].push_back(e);
                n_iss++;
            end
            for (int c = 0; c < 4; c++)
                if (acc[c]) iss_q[c].push_back(in_data[c*DW +: DW]);
            if (en_s) slot_m = (slot_m + 1) % 4;
            if (mism) err_m = 1'b1;
            for (int c = 0; c < 4; c++) begin
                exp_pulse = (out_q[c].size() != 0) && (out_q[c][0].due == cyc);
                check("out_valid", out_valid[c], exp_pulse);
                if (exp_pulse) begin
                    e = out_q[c].pop_front();
                    check("out_data", out_data[c*DW +: DW], e.d);
                end
            end
            exp_iss = en3_s && (slot3_m == 2) && (q3.size() != 0);
            check("fir_in_valid3", fir_in_valid3, exp_iss);
            if (exp_iss) begin
                d = q3.pop_front();
                check("fir_in_ch3", fir_in_ch3, 2);
                check("fir_in_data3", fir_in_data3, d);
                e.d   = d + 1'b1;
                e.due = cyc + L + 1;
                o3.push_back(e);
                n_iss3++;
            end
            if (acc3[2]) q3.push_back(in_data3[2*DW +: DW]);
            if (en3_s) slot3_m = (slot3_m + 1) % 3;
            exp_pulse = (o3.size() != 0) && (o3[0].due == cyc);
            check("out_valid3", out_valid3, {exp_pulse, 2'b00});
            if (exp_pulse) begin
                e = o3.pop_front();
                check("out_data3", out_data3[2*DW +: DW], e.d);
            end
        end
        check("slot", slot, slot_m);
        check("slot3", slot3, slot3_m);
        check("sync_err", sync_err, err_m);
        check("sync_err3", sync_err3, 0);
        for (int i = L; i > 0; i--) begin
            pv[i]  = pv[i-1];
            pd[i]  = pd[i-1];
            pv3[i] = pv3[i-1];
            pd3[i] = pd3[i-1];
        end
        pv[0]  = fir_in_valid;
        pd[0]  = fir_in_data + 1'b1;
        pv3[0] = fir_in_valid3;
        pd3[0] = fir_in_data3 + 1'b1;
        fir_out_valid  = pv[L] | force_fov;
        fir_out_data   = pd[L];
        fir_out_valid3 = pv3[L];
        fir_out_data3  = pd3[L];
        force_fov = 1'b0;
        for (int c = 0; c < 4; c++)
            if (acc[c]) k[c]++;
        if (mode == M_SEQ) begin
            for (int c = 0; c < 4; c++) in_data[c*DW +: DW] = DW'(100 * c + k[c]);
        end else if (mode == M_RAND) begin
            in_valid = 4'($urandom);
            enable   = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < 4; c++)
                if (acc[c]) in_data[c*DW +: DW] = DW'($urandom);
        end
        if (acc3[2]) k3++;
        in_data3[2*DW +: DW] = DW'(200 + k3);
    endtask

    initial begin
        int n0;
        int s0;
        reset = 1'b1;
        enable = 1'b0; in_valid = '0; in_data = '0;
        fir_out_valid = 1'b0; fir_out_data = '0;
        enable3 = 1'b1; in_valid3 = 3'b100; in_data3 = '0;
        fir_out_valid3 = 1'b0; fir_out_data3 = '0;
        force_fov = 1'b0; mode = M_HOLD; k3 = 0;
        for (int c = 0; c < 4; c++) k[c] = 0;
        repeat (2) step();
        reset = 1'b0;

        // Full load: every channel always offering 100c+k.
        mode = M_SEQ;
        for (int c = 0; c < 4; c++) in_data[c*DW +: DW] = DW'(100 * c);
        in_valid = 4'hF;
        enable = 1'b1;
        repeat (10) step();
        n0 = n_iss;
        repeat (16) step();
        check("full_load_rate", n_iss - n0, 16);

        // Reset for 3 cycles in the middle of traffic.
        reset = 1'b1;
        repeat (3) step();
        check("rst_fir_in_valid", fir_in_valid, 0);
        check("rst_fir_in_data", fir_in_data, 0);
        check("rst_fir_in_ch", fir_in_ch, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data_lo", out_data[31:0], 0);
        check("rst_out_data_hi", out_data[63:32], 0);
        check("rst_in_ready", in_ready, 4'hF);
        check("rst_sync_err", sync_err, 0);
        reset = 1'b0;
        repeat (12) step();
        n0 = n_iss;
        repeat (20) step();
        check("full_load_rate_after_reset", n_iss - n0, 20);

        // Backpressure: ch1 keeps offering while the scheduler is stalled.
        mode = M_HOLD;
        in_valid = 4'b0010;
        in_data[1*DW +: DW] = 16'h1234;
        enable = 1'b0;
        s0 = slot_m;
        repeat (10) step();
        check("bp_slot_frozen", slot, s0);
        check("bp_in_ready1", in_ready[1], 0);
        check("bp_results_drained", out_q[0].size() + out_q[1].size() + out_q[2].size() + out_q[3].size(), 0);
        enable = 1'b1;
        in_valid = 4'b0000;
        repeat (20) step();

        // Sparse: only ch2, with a value whose +1 wraps the sign bit.
        in_valid = 4'b0100;
        in_data[2*DW +: DW] = 16'h7FFF;
        repeat (24) step();
        in_valid = 4'b0000;
        repeat (14) step();
        check("sparse_out_data2", out_data[2*DW +: DW], 16'h8000);

        // Randomized traffic with random stalls.
        mode = M_RAND;
        repeat (300) step();
        mode = M_HOLD;
        in_valid = 4'b0000;
        enable = 1'b1;
        repeat (24) step();
        in_valid3 = 3'b000;
        repeat (16) step();
        check("all_results_delivered", pending(), 0);

        // Sync error: spurious FIR strobe in an otherwise idle cycle.
        force_fov = 1'b1;
        step();
        step();
        check("sync_err_set", sync_err, 1);
        repeat (5) step();
        check("sync_err_sticky", sync_err, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("sync_err_cleared", sync_err, 0);
        step();

        check("dut3_activity", n_iss3 > 50, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
